regfile_ctrl: RTL

- Command sequencer that drives the 8x16 register file's write port (data_in/writenum/write) and read port (readnum/data_out).
- Accepts move, read and swap commands over a valid/ready handshake.
- Performs each command as a short multi-cycle read/modify/write sequence.
- Returns read results over a valid/ready response channel.
- Sits between the instruction decoder and the register file; it is the only agent that asserts the register file's write.

---
 rtl/regfile_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/regfile_ctrl.sv
// Command sequencer for an 8x16 register file: MOVI / MOV / READ / SWAP
// executed as short read-modify-write sequences, READ results returned over
// a valid/ready response channel.
module regfile_ctrl #(
    parameter int unsigned DW   = 16,
    parameter int unsigned IMMW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [2:0]      cmd_rd,
    input  logic [2:0]      cmd_rm,
    input  logic [IMMW-1:0] cmd_imm,
    input  logic [1:0]      cmd_sh,
    output logic [DW-1:0]   rf_data_in,
    output logic [2:0]      rf_writenum,
    output logic            rf_write,
    output logic [2:0]      rf_readnum,
    input  logic [DW-1:0]   rf_data_out,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_data,
    output logic            busy
);

    typedef enum logic [2:0] {
        StIdle,
        StReadA,
        StReadB,
        StWrite1,
        StWrite2,
        StResp
    } state_e;

    localparam logic [1:0] OpMovi = 2'b00;
    localparam logic [1:0] OpMov  = 2'b01;
    localparam logic [1:0] OpRead = 2'b10;
    localparam logic [1:0] OpSwap = 2'b11;

    localparam logic [1:0] ShLsl1 = 2'b01;
    localparam logic [1:0] ShLsr1 = 2'b10;
    localparam logic [1:0] ShAsr1 = 2'b11;

    state_e          state_q, state_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic [1:0]      op_q, op_d;
    logic [2:0]      rd_q, rd_d;
    logic [2:0]      rm_q, rm_d;
    logic [IMMW-1:0] imm_q, imm_d;
    logic [1:0]      sh_q, sh_d;

    logic [DW-1:0]   imm_sext;
    logic [DW-1:0]   a_shifted;

    // Immediate sign extension and MOV shifter, both from registered fields only.
    always_comb begin
        imm_sext = {{(DW - IMMW){imm_q[IMMW-1]}}, imm_q};
        case (sh_q)
            ShLsl1:  a_shifted = {a_q[DW-2:0], 1'b0};
            ShLsr1:  a_shifted = {1'b0, a_q[DW-1:1]};
            ShAsr1:  a_shifted = {a_q[DW-1], a_q[DW-1:1]};
            default: a_shifted = a_q;
        endcase
    end

    // Next-state logic: sequencing, operand capture and command latch.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rm_d    = rm_q;
        imm_d   = imm_q;
        sh_d    = sh_q;
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    rd_d    = cmd_rd;
                    rm_d    = cmd_rm;
                    imm_d   = cmd_imm;
                    sh_d    = cmd_sh;
                    state_d = (cmd_op == OpMovi) ? StWrite1 : StReadA;
                end
            end
            StReadA: begin
                a_d = rf_data_out;
                case (op_q)
                    OpMov:   state_d = StWrite1;
                    OpRead:  state_d = StResp;
                    default: state_d = StReadB;
                endcase
            end
            StReadB: begin
                b_d     = rf_data_out;
                state_d = StWrite1;
            end
            StWrite1: state_d = (op_q == OpSwap) ? StWrite2 : StIdle;
            StWrite2: state_d = StIdle;
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state and registered fields only.
    always_comb begin
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        rf_write    = 1'b0;
        rf_writenum = '0;
        rf_data_in  = '0;
        rf_readnum  = '0;
        rsp_valid   = 1'b0;
        rsp_data    = '0;
        case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            StReadA: rf_readnum = rm_q;
            StReadB: rf_readnum = rd_q;
            StWrite1: begin
                rf_write    = 1'b1;
                rf_writenum = rd_q;
                case (op_q)
                    OpMovi:  rf_data_in = imm_sext;
                    OpMov:   rf_data_in = a_shifted;
                    default: rf_data_in = a_q;
                endcase
            end
            StWrite2: begin
                rf_write    = 1'b1;
                rf_writenum = rm_q;
                rf_data_in  = b_q;
            end
            StResp: begin
                rsp_valid = 1'b1;
                rsp_data  = a_q;
            end
            default: ;
        endcase
    end

    // State and field registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            rm_q    <= '0;
            imm_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rm_q    <= rm_d;
            imm_q   <= imm_d;
            sh_q    <= sh_d;
        end
    end

endmodule
